// File: rtl/group_change_scanner.sv
// Purpose: scan the 16 groups of a 128-to-8 mux and queue {group, data} events for groups whose value changed.
// Latency: one group per DWELL+1 cycles; an event is visible at the FIFO head on the cycle after its sample.
// Backpressure: events wait in a FWFT FIFO; a change seen while the FIFO is full sets sticky overflow and is retried next sweep.

// Generic first-word-fall-through FIFO; a push while full is taken only together with a pop.
module gcs_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Read/write pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end
endmodule

module group_change_scanner #(
  parameter int DWELL      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iEnable,
  output logic [3:0] ovSel,
  input  logic [7:0] ivGroupData,
  output logic       oEvtValid,
  output logic [3:0] ovEvtGroup,
  output logic [7:0] ovEvtData,
  input  logic       iEvtReady,
  output logic       oOverflow,
  input  logic       iClrOverflow,
  output logic       oBaselineValid,
  output logic       oSweepDone
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] dwell_cnt;
  logic [3:0] dwell_cnt_nxt;
  logic [3:0] sel_nxt;
  logic       sample_vld;

  logic [7:0]  shadow [16];
  logic        differs;
  logic        can_accept;
  logic        evt_push;
  logic        evt_pop;
  logic        ovf_set;
  logic        shadow_wr;
  logic        fifo_full;
  logic        fifo_empty;
  logic [11:0] head_dat;

  // Sequencer registers: state, dwell counter and the mux select.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      ovSel     <= '0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      ovSel     <= sel_nxt;
    end
  end

  // Next-state: hold the select DWELL cycles, sample once, then advance or park in IDLE.
  always_comb begin
    state_nxt     = state;
    dwell_cnt_nxt = dwell_cnt;
    sel_nxt       = ovSel;
    sample_vld    = 1'b0;
    case (state)
      IDLE: begin
        sel_nxt = 4'd0;
        if (iEnable) begin
          state_nxt     = SETTLE;
          dwell_cnt_nxt = 4'd0;
        end
      end
      SETTLE: begin
        if (dwell_cnt == DWELL_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          dwell_cnt_nxt = dwell_cnt + 4'd1;
        end
      end
      SAMPLE: begin
        sample_vld    = 1'b1;
        dwell_cnt_nxt = 4'd0;
        if (!iEnable) begin
          state_nxt = IDLE;
          sel_nxt   = 4'd0;
        end else begin
          state_nxt = SETTLE;
          sel_nxt   = ovSel + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = 4'd0;
      end
    endcase
  end

  assign oSweepDone = sample_vld && (ovSel == 4'd15);
  assign evt_pop    = oEvtValid && iEvtReady;

  // Change detection: a refused change leaves the shadow stale so the next sweep finds it again.
  always_comb begin
    differs    = (ivGroupData != shadow[ovSel]);
    can_accept = !fifo_full || evt_pop;
    evt_push   = sample_vld && oBaselineValid && differs && can_accept;
    ovf_set    = sample_vld && oBaselineValid && differs && !can_accept;
    shadow_wr  = sample_vld && (!oBaselineValid || evt_push);
  end

  // Shadow copy of the last accepted value of each group.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else if (shadow_wr) begin
      shadow[ovSel] <= ivGroupData;
    end
  end

  // Baseline flag: set after a complete sweep, dropped whenever scanning stops.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oBaselineValid <= 1'b0;
    end else if (sample_vld) begin
      if (!iEnable)             oBaselineValid <= 1'b0;
      else if (ovSel == 4'd15)  oBaselineValid <= 1'b1;
    end
  end

  // Sticky overflow; a new overflow in the same cycle beats the clear.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oOverflow <= 1'b0;
    end else if (ovf_set) begin
      oOverflow <= 1'b1;
    end else if (iClrOverflow) begin
      oOverflow <= 1'b0;
    end
  end

  gcs_fifo #(
    .WIDTH (12),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk      (iClk),
    .rst_n    (iRst_n),
    .push     (evt_push),
    .push_dat ({ovSel, ivGroupData}),
    .pop      (evt_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign oEvtValid  = !fifo_empty;
  assign ovEvtGroup = head_dat[11:8];
  assign ovEvtData  = head_dat[7:0];
endmodule

// File: tb/tb_group_change_scanner.sv
// Bench for group_change_scanner: directed scenarios followed by random traffic.
// A cycle-level reference model predicts select, flags and the event stream.
// A negedge monitor compares DUT outputs and pops expected events on each handshake.
module tb_group_change_scanner;
  localparam int DWELL = 2;
  localparam int DEPTH = 4;
  localparam int GP    = DWELL + 1;
  localparam int SWEEP = 16 * GP;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iEnable = 1'b1;
  logic [3:0] ovSel;
  logic [7:0] ivGroupData;
  logic       oEvtValid;
  logic [3:0] ovEvtGroup;
  logic [7:0] ovEvtData;
  logic       iEvtReady = 1'b1;
  logic       oOverflow;
  logic       iClrOverflow = 1'b0;
  logic       oBaselineValid;
  logic       oSweepDone;

  logic [7:0] grp_val [16];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_active = 0;
  int          m_t = 0;
  bit          m_baseline = 0;
  logic [7:0]  m_shadow [16];
  int          m_n = 0;
  bit          m_ovf = 0;
  logic [11:0] sb_q [$];

  always #5 iClk = ~iClk;

  assign ivGroupData = grp_val[ovSel];

  group_change_scanner #(.DWELL(DWELL), .FIFO_DEPTH(DEPTH)) dut (
    .iClk           (iClk),
    .iRst_n         (iRst_n),
    .iEnable        (iEnable),
    .ovSel          (ovSel),
    .ivGroupData    (ivGroupData),
    .oEvtValid      (oEvtValid),
    .ovEvtGroup     (ovEvtGroup),
    .ovEvtData      (ovEvtData),
    .iEvtReady      (iEvtReady),
    .oOverflow      (oOverflow),
    .iClrOverflow   (iClrOverflow),
    .oBaselineValid (oBaselineValid),
    .oSweepDone     (oSweepDone)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] exp_sel();
    return m_active ? 4'((m_t / GP) % 16) : 4'd0;
  endfunction

  function automatic logic exp_done();
    return m_active && (m_t % GP == DWELL) && ((m_t / GP) % 16 == 15);
  endfunction

  task automatic model_reset();
    m_active   = 0;
    m_t        = 0;
    m_baseline = 0;
    m_n        = 0;
    m_ovf      = 0;
    for (int i = 0; i < 16; i++) m_shadow[i] = 8'h00;
    sb_q.delete();
  endtask

  // Reference model: one step per clock, written in terms of sweep time rather than FSM states.
  always @(posedge iClk or negedge iRst_n) begin
    int g;
    bit smp, pop_m, push_m, oset;
    if (!iRst_n) begin
      model_reset();
    end else begin
      g      = (m_t / GP) % 16;
      smp    = m_active && (m_t % GP == DWELL);
      pop_m  = (m_n > 0) && iEvtReady;
      push_m = 0;
      oset   = 0;
      if (smp) begin
        if (!m_baseline) begin
          m_shadow[g] = grp_val[g];
        end else if (grp_val[g] != m_shadow[g]) begin
          if (m_n < DEPTH || pop_m) begin
            push_m      = 1;
            m_shadow[g] = grp_val[g];
            sb_q.push_back({4'(g), grp_val[g]});
          end else begin
            oset = 1;
          end
        end
      end
      if (oset) m_ovf = 1;
      else if (iClrOverflow) m_ovf = 0;
      m_n = m_n - int'(pop_m) + int'(push_m);
      if (!m_active) begin
        if (iEnable) begin
          m_active = 1;
          m_t      = 0;
        end
      end else if (smp) begin
        if (g == 15 && iEnable) m_baseline = 1;
        if (!iEnable) begin
          m_active   = 0;
          m_baseline = 0;
        end else begin
          m_t = (m_t + 1) % SWEEP;
        end
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  // Monitor: compare flags every cycle and consume one expected event per handshake.
  always @(negedge iClk) begin
    logic [11:0] e_evt;
    check("sel", {28'd0, ovSel}, {28'd0, exp_sel()});
    check("sweep_done", {31'd0, oSweepDone}, {31'd0, exp_done()});
    check("baseline_valid", {31'd0, oBaselineValid}, {31'd0, m_baseline});
    check("overflow", {31'd0, oOverflow}, {31'd0, m_ovf});
    check("evt_valid", {31'd0, oEvtValid}, {31'd0, (m_n > 0)});
    if (iRst_n && oEvtValid && iEvtReady) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_evt: got {%0d,%0h}, expected no event at %0t", ovEvtGroup, ovEvtData, $time);
      end else begin
        e_evt = sb_q.pop_front();
        check("evt_group", {28'd0, ovEvtGroup}, {28'd0, e_evt[11:8]});
        check("evt_data", {24'd0, ovEvtData}, {24'd0, e_evt[7:0]});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #2;
  endtask

  task automatic wait_sel(input logic [3:0] v);
    int n;
    n = 0;
    while (ovSel == v && n < 4 * SWEEP) begin tick(1); n++; end
    while (ovSel != v && n < 4 * SWEEP) begin tick(1); n++; end
    if (ovSel != v) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_sel timeout: ovSel=%0d, expected %0d", ovSel, v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"}, {28'd0, ovSel}, 32'd0);
    check({tag, "_evt_valid"}, {31'd0, oEvtValid}, 32'd0);
    check({tag, "_evt_group"}, {28'd0, ovEvtGroup}, 32'd0);
    check({tag, "_evt_data"}, {24'd0, ovEvtData}, 32'd0);
    check({tag, "_overflow"}, {31'd0, oOverflow}, 32'd0);
    check({tag, "_baseline"}, {31'd0, oBaselineValid}, 32'd0);
    check({tag, "_sweep_done"}, {31'd0, oSweepDone}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) grp_val[i] = 8'hA5;
    #1;
    check_reset_outputs("rst");
    #12 iRst_n = 1'b1;

    // T1: static data, baseline then quiet compare sweeps
    tick(2 * SWEEP + 10);
    check("t1_baseline", {31'd0, oBaselineValid}, 32'd1);

    // T2: single change on group 5
    grp_val[5] = 8'h3C;
    tick(3 * SWEEP);

    // T3: six changes in one sweep with the consumer stalled
    wait_sel(4'd0);
    iEvtReady = 1'b0;
    for (int i = 1; i <= 6; i++) grp_val[i] = 8'(8'h10 + i);
    tick(SWEEP);
    check("t3_overflow", {31'd0, oOverflow}, 32'd1);
    iEvtReady = 1'b1;
    tick(8);
    iClrOverflow = 1'b1;
    tick(1);
    iClrOverflow = 1'b0;
    tick(2 * SWEEP);

    // T4: full FIFO, pop and push of group 9 in the same sample cycle
    wait_sel(4'd0);
    iEvtReady = 1'b0;
    for (int i = 1; i <= 4; i++) grp_val[i] = grp_val[i] ^ 8'hFF;
    grp_val[9] = 8'h99;
    wait_sel(4'd9);
    tick(DWELL);
    iEvtReady = 1'b1;
    tick(1);
    iEvtReady = 1'b0;
    check("t4_overflow", {31'd0, oOverflow}, 32'd0);
    check("t4_still_full_valid", {31'd0, oEvtValid}, 32'd1);
    iEvtReady = 1'b1;
    tick(2 * SWEEP);

    // T5: stop at group 7 with events queued, then restart
    iEvtReady = 1'b0;
    wait_sel(4'd0);
    grp_val[2] = 8'h5A;
    wait_sel(4'd7);
    iEnable = 1'b0;
    tick(2 * GP + 5);
    check("t5_idle_sel", {28'd0, ovSel}, 32'd0);
    check("t5_baseline", {31'd0, oBaselineValid}, 32'd0);
    check("t5_queued", {31'd0, oEvtValid}, 32'd1);
    iEvtReady = 1'b1;
    tick(6);
    grp_val[3] = grp_val[3] ^ 8'h55;
    iEnable = 1'b1;
    tick(SWEEP + GP);
    tick(SWEEP);

    // T6: asynchronous reset mid-SETTLE with two events queued
    iEvtReady = 1'b0;
    wait_sel(4'd0);
    grp_val[4] = grp_val[4] ^ 8'h01;
    grp_val[8] = grp_val[8] ^ 8'h01;
    wait_sel(4'd10);
    tick(1);
    check("t6_pre_valid", {31'd0, oEvtValid}, 32'd1);
    #1 iRst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    tick(2);
    iRst_n = 1'b1;
    iEvtReady = 1'b1;
    tick(SWEEP + 5);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      iEvtReady    = ($urandom_range(0, 3) != 0);
      iClrOverflow = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) grp_val[$urandom_range(0, 15)] = 8'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        iEnable = 1'b0;
        tick($urandom_range(1, 30));
        iEnable = 1'b1;
      end
      tick(1);
    end

    // Wind down and drain
    iClrOverflow = 1'b0;
    iEnable = 1'b0;
    tick(GP + 2);
    iEvtReady = 1'b1;
    tick(10);
    check("final_empty", {31'd0, oEvtValid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
